// File: rtl/lvda_timing_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : lvda_timing_pkg
//  Purpose : Shared types and phase constants for the LVDA timing-chain
//            sequencer. A frame is 4 slots (W,X,Y,Z) x 4 sub-phases, giving
//            phase index p = slot*4 + (sub-1), p = 0..15.
//  Ports   : none (package)
//  Rev     : 1.0  initial release
// ============================================================================
package lvda_timing_pkg;

    // Slot ordering inside a frame; the slot is the upper two bits of p.
    typedef enum logic [1:0] {
        SLOT_W = 2'd0,
        SLOT_X = 2'd1,
        SLOT_Y = 2'd2,
        SLOT_Z = 2'd3
    } slot_e;

    localparam int PHASES_PER_FRAME = 16;

    // Phase indices at which the set strobes fire.
    localparam logic [3:0] P_FRAME = 4'd0;
    localparam logic [3:0] P_W3    = 4'd2;
    localparam logic [3:0] P_X3    = 4'd6;
    localparam logic [3:0] P_Y3    = 4'd10;
    localparam logic [3:0] P_Z1    = 4'd12;
    localparam logic [3:0] P_LAST  = 4'(PHASES_PER_FRAME - 1);

    // Sequencer FSM states.
    typedef enum logic [1:0] {
        ST_HALT = 2'd0,
        ST_RUN  = 2'd1,
        ST_STEP = 2'd2
    } seq_state_e;

endpackage
`default_nettype wire

// File: rtl/lvda_phase_counter.sv
`default_nettype none
// ============================================================================
//  Module  : lvda_phase_counter
//  Purpose : Sub-phase tick counter and 16-step phase counter for one LVDA
//            frame. Tick counts 0..SUB_TICKS-1; phase advances when tick
//            wraps. Clear has priority over enable and forces both to zero.
//  Ports   : clk          in   clock
//            rst          in   synchronous reset, active-high
//            i_en         in   advance counters this cycle
//            i_clr        in   force tick/phase to zero
//            o_phase      out  current phase index p (0..15)
//            o_tick_zero  out  tick == 0 (first clock of the sub-phase)
//            o_frame_end  out  last tick of phase 15
//  Rev     : 1.0  initial release
// ============================================================================
module lvda_phase_counter
    import lvda_timing_pkg::*;
#(
    parameter int SUB_TICKS = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_en,
    input  logic       i_clr,
    output logic [3:0] o_phase,
    output logic       o_tick_zero,
    output logic       o_frame_end
);

    // A one-tick sub-phase still needs a 1-bit counter to keep widths legal.
    localparam int c_TICK_W = (SUB_TICKS > 1) ? $clog2(SUB_TICKS) : 1;
    localparam logic [c_TICK_W-1:0] c_TICK_LAST = c_TICK_W'(SUB_TICKS - 1);

    logic [c_TICK_W-1:0] r_tick_q;
    logic [c_TICK_W-1:0] w_tick_d;
    logic [3:0]          r_phase_q;
    logic [3:0]          w_phase_d;
    logic                w_tick_wrap;

    assign w_tick_wrap = (r_tick_q == c_TICK_LAST);

    always_comb begin
        w_tick_d  = r_tick_q;
        w_phase_d = r_phase_q;
        if (i_clr) begin
            w_tick_d  = '0;
            w_phase_d = '0;
        end else if (i_en) begin
            if (w_tick_wrap) begin
                w_tick_d  = '0;
                // Natural 4-bit wrap returns phase 15 to phase 0.
                w_phase_d = r_phase_q + 4'd1;
            end else begin
                w_tick_d  = r_tick_q + c_TICK_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tick_q  <= '0;
            r_phase_q <= '0;
        end else begin
            r_tick_q  <= w_tick_d;
            r_phase_q <= w_phase_d;
        end
    end

    assign o_phase     = r_phase_q;
    assign o_tick_zero = (r_tick_q == '0);
    assign o_frame_end = (r_phase_q == P_LAST) && w_tick_wrap;

endmodule
`default_nettype wire

// File: rtl/lvda_phase_sequencer.sv
`default_nettype none
// ============================================================================
//  Module  : lvda_phase_sequencer
//  Purpose : Generates the W3/X3/Y3/Z1 set strobes and V1/V4 hold levels for
//            the LVDA timing latches. Runs frames continuously while RUN is
//            high, or exactly one frame per STEP rising edge while halted.
//            Halting only ever happens at a frame boundary.
//  Ports   : SIM_CLK      in   sole clock
//            SIM_RST      in   synchronous reset, active-high
//            RUN          in   level, free-run frames while high
//            STEP         in   rising edge while halted runs one frame
//            W3,X3,Y3     out  slot sub-phase 3 set strobes (1 clk)
//            Z1           out  Z slot sub-phase 1 set strobe (1 clk)
//            V1           out  hold level, low during X3/Y3/Z1
//            V4           out  hold level, low during W3/X3/Y3/Z1
//            FRAME_START  out  1-clk pulse on first tick of each frame
//            HALTED       out  high while halted
//            FRAME_CNT    out  completed-frame count, wraps
//  Rev     : 1.0  initial release
// ============================================================================
module lvda_phase_sequencer
    import lvda_timing_pkg::*;
#(
    parameter int SUB_TICKS   = 1,
    parameter int FRAME_CNT_W = 8
) (
    input  logic                   SIM_CLK,
    input  logic                   SIM_RST,
    input  logic                   RUN,
    input  logic                   STEP,
    output logic                   W3,
    output logic                   X3,
    output logic                   Y3,
    output logic                   Z1,
    output logic                   V1,
    output logic                   V4,
    output logic                   FRAME_START,
    output logic                   HALTED,
    output logic [FRAME_CNT_W-1:0] FRAME_CNT
);

    seq_state_e             r_state_q;
    seq_state_e             w_state_d;
    logic                   r_step_q;
    logic                   w_step_d;
    logic [FRAME_CNT_W-1:0] r_frame_cnt_q;
    logic [FRAME_CNT_W-1:0] w_frame_cnt_d;

    logic       w_active;
    logic       w_step_rise;
    logic [3:0] w_phase;
    logic       w_tick_zero;
    logic       w_frame_end;
    logic       w_strobe_ok;

    assign w_active    = (r_state_q != ST_HALT);
    assign w_step_rise = STEP & ~r_step_q;

    // Counters are held cleared while halted so every frame starts at p=0.
    lvda_phase_counter #(
        .SUB_TICKS (SUB_TICKS)
    ) u_phase_counter (
        .clk         (SIM_CLK),
        .rst         (SIM_RST),
        .i_en        (w_active),
        .i_clr       (~w_active),
        .o_phase     (w_phase),
        .o_tick_zero (w_tick_zero),
        .o_frame_end (w_frame_end)
    );

    always_comb begin
        w_state_d     = r_state_q;
        w_frame_cnt_d = r_frame_cnt_q;
        // The edge register follows STEP in every state, so an edge that
        // arrives mid-frame is consumed and never replayed after halting.
        w_step_d      = STEP;
        case (r_state_q)
            ST_HALT: begin
                if (RUN) begin
                    w_state_d = ST_RUN;
                end else if (w_step_rise) begin
                    w_state_d = ST_STEP;
                end
            end
            ST_RUN, ST_STEP: begin
                if (w_frame_end) begin
                    w_frame_cnt_d = r_frame_cnt_q + 1'b1;
                    w_state_d     = RUN ? ST_RUN : ST_HALT;
                end
            end
            default: begin
                w_state_d = ST_HALT;
            end
        endcase
    end

    always_ff @(posedge SIM_CLK) begin
        if (SIM_RST) begin
            r_state_q     <= ST_HALT;
            r_step_q      <= 1'b0;
            r_frame_cnt_q <= '0;
        end else begin
            r_state_q     <= w_state_d;
            r_step_q      <= w_step_d;
            r_frame_cnt_q <= w_frame_cnt_d;
        end
    end

    // Strobes are a direct decode of registered state, phase and tick.
    assign w_strobe_ok = w_active & w_tick_zero;
    assign FRAME_START = w_strobe_ok & (w_phase == P_FRAME);
    assign W3          = w_strobe_ok & (w_phase == P_W3);
    assign X3          = w_strobe_ok & (w_phase == P_X3);
    assign Y3          = w_strobe_ok & (w_phase == P_Y3);
    assign Z1          = w_strobe_ok & (w_phase == P_Z1);
    assign V4          = ~(W3 | X3 | Y3 | Z1);
    assign V1          = ~(X3 | Y3 | Z1);
    assign HALTED      = (r_state_q == ST_HALT);
    assign FRAME_CNT   = r_frame_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_lvda_phase_sequencer.sv
`default_nettype none
// ============================================================================
//  Module  : tb_lvda_phase_sequencer
//  Purpose : Self-checking bench. Two sequencer instances: A with SUB_TICKS=1
//            and an 8-bit frame counter, B with SUB_TICKS=3 and a 2-bit frame
//            counter. Expected strobe events (cycle, kind, frame count) are
//            queued when stimulus is applied and matched as strobes appear.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_lvda_phase_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       a_rst = 1'b1, a_run = 1'b0, a_step = 1'b0;
    logic       a_w3, a_x3, a_y3, a_z1, a_v1, a_v4, a_fs, a_halted;
    logic [7:0] a_cnt;
    logic       b_rst = 1'b1, b_run = 1'b0, b_step = 1'b0;
    logic       b_w3, b_x3, b_y3, b_z1, b_v1, b_v4, b_fs, b_halted;
    logic [1:0] b_cnt;

    lvda_phase_sequencer #(.SUB_TICKS(1), .FRAME_CNT_W(8)) u_dut_a (
        .SIM_CLK(clk), .SIM_RST(a_rst), .RUN(a_run), .STEP(a_step),
        .W3(a_w3), .X3(a_x3), .Y3(a_y3), .Z1(a_z1), .V1(a_v1), .V4(a_v4),
        .FRAME_START(a_fs), .HALTED(a_halted), .FRAME_CNT(a_cnt)
    );

    lvda_phase_sequencer #(.SUB_TICKS(3), .FRAME_CNT_W(2)) u_dut_b (
        .SIM_CLK(clk), .SIM_RST(b_rst), .RUN(b_run), .STEP(b_step),
        .W3(b_w3), .X3(b_x3), .Y3(b_y3), .Z1(b_z1), .V1(b_v1), .V4(b_v4),
        .FRAME_START(b_fs), .HALTED(b_halted), .FRAME_CNT(b_cnt)
    );

    typedef struct {
        int cyc;
        int ev;
        int cnt;
    } exp_t;

    // Event code bits: {FRAME_START, W3, X3, Y3, Z1}
    localparam int c_EV_FS = 16;
    localparam int c_EV_W3 = 8;
    localparam int c_EV_X3 = 4;
    localparam int c_EV_Y3 = 2;
    localparam int c_EV_Z1 = 1;

    int   ev_list [5] = '{c_EV_FS, c_EV_W3, c_EV_X3, c_EV_Y3, c_EV_Z1};
    int   p_list  [5] = '{0, 2, 6, 10, 12};

    exp_t qa[$];
    exp_t qb[$];
    int   cyc       = 0;
    int   n_vec     = 0;
    int   n_err     = 0;
    bit   mon_en    = 1'b0;
    int   b_v4_low  = 0;
    int   b_v1_low  = 0;
    int   ev_a, ev_b;
    exp_t e_a, e_b;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cyc %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic push_frame(input bit to_b, input int start, input int st,
                              input int cnt, input int n_ev);
        exp_t e;
        for (int i = 0; i < n_ev; i++) begin
            e.cyc = start + p_list[i] * st;
            e.ev  = ev_list[i];
            e.cnt = cnt;
            if (to_b) qb.push_back(e);
            else      qa.push_back(e);
        end
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitors sample on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (mon_en) begin
            ev_a = int'({a_fs, a_w3, a_x3, a_y3, a_z1});
            if (ev_a != 0) begin
                if (qa.size() == 0) begin
                    check("a_unexpected_strobe", ev_a, 0);
                end else begin
                    e_a = qa.pop_front();
                    check("a_event", ev_a, e_a.ev);
                    check("a_cycle", cyc, e_a.cyc);
                    check("a_frame_cnt", int'(a_cnt), e_a.cnt);
                    check("a_halted_in_frame", int'(a_halted), 0);
                    check("a_v4", int'(a_v4), ((e_a.ev & 15) != 0) ? 0 : 1);
                    check("a_v1", int'(a_v1), ((e_a.ev & 7) != 0) ? 0 : 1);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            if (b_v4 === 1'b0) b_v4_low++;
            if (b_v1 === 1'b0) b_v1_low++;
            ev_b = int'({b_fs, b_w3, b_x3, b_y3, b_z1});
            if (ev_b != 0) begin
                if (qb.size() == 0) begin
                    check("b_unexpected_strobe", ev_b, 0);
                end else begin
                    e_b = qb.pop_front();
                    check("b_event", ev_b, e_b.ev);
                    check("b_cycle", cyc, e_b.cyc);
                    check("b_frame_cnt", int'(b_cnt), e_b.cnt);
                    check("b_v4", int'(b_v4), ((e_b.ev & 15) != 0) ? 0 : 1);
                    check("b_v1", int'(b_v1), ((e_b.ev & 7) != 0) ? 0 : 1);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, cyc %0d", cyc);
        $fatal(1);
    end

    initial begin
        int c;
        int s;

        wait_cyc(3);
        mon_en = 1'b1;

        // Reset state
        check("rst_halted", int'(a_halted), 1);
        check("rst_v1", int'(a_v1), 1);
        check("rst_v4", int'(a_v4), 1);
        check("rst_cnt", int'(a_cnt), 0);
        check("rst_strobes", int'({a_fs, a_w3, a_x3, a_y3, a_z1}), 0);
        check("rst_b_halted", int'(b_halted), 1);

        // Free run from reset, then drop RUN at p=5 of the third frame
        a_rst = 1'b0;
        a_run = 1'b1;
        c = cyc;
        s = c + 1;
        push_frame(1'b0, s,      1, 0, 5);
        push_frame(1'b0, s + 16, 1, 1, 5);
        push_frame(1'b0, s + 32, 1, 2, 5);
        wait_cyc(s + 16);
        check("run_cnt_after_frame1", int'(a_cnt), 1);
        wait_cyc(s + 32 + 5);
        a_run = 1'b0;
        wait_cyc(s + 47);
        check("drop_run_still_running", int'(a_halted), 0);
        wait_cyc(s + 48);
        check("drop_run_halted", int'(a_halted), 1);
        check("drop_run_cnt", int'(a_cnt), 3);
        wait_cyc(s + 68);
        check("idle_halted", int'(a_halted), 1);
        check("idle_v1", int'(a_v1), 1);
        check("idle_v4", int'(a_v4), 1);
        check("idle_queue_empty", qa.size(), 0);

        // Single-step: one-clock pulse
        c = cyc;
        a_step = 1'b1;
        push_frame(1'b0, c + 1, 1, 3, 5);
        wait_cyc(c + 1);
        a_step = 1'b0;
        wait_cyc(c + 17);
        check("step1_halted", int'(a_halted), 1);
        check("step1_cnt", int'(a_cnt), 4);

        // Single-step: STEP held high for 40 clocks
        wait_cyc(cyc + 3);
        c = cyc;
        a_step = 1'b1;
        push_frame(1'b0, c + 1, 1, 4, 5);
        wait_cyc(c + 40);
        a_step = 1'b0;
        check("step_held_halted", int'(a_halted), 1);
        check("step_held_cnt", int'(a_cnt), 5);

        // Second pulse; an extra STEP edge mid-frame must be ignored
        wait_cyc(cyc + 4);
        c = cyc;
        a_step = 1'b1;
        push_frame(1'b0, c + 1, 1, 5, 5);
        wait_cyc(c + 1);
        a_step = 1'b0;
        wait_cyc(c + 6);
        a_step = 1'b1;
        wait_cyc(c + 7);
        a_step = 1'b0;
        wait_cyc(c + 24);
        check("step2_halted", int'(a_halted), 1);
        check("step2_cnt", int'(a_cnt), 6);
        check("step_queue_empty", qa.size(), 0);

        // Reset at p=9 during RUN: no Y3/Z1, then restart from p=0
        c = cyc;
        a_run = 1'b1;
        s = c + 1;
        push_frame(1'b0, s, 1, 6, 3);
        wait_cyc(s + 9);
        a_rst = 1'b1;
        wait_cyc(s + 10);
        check("midrst_halted", int'(a_halted), 1);
        check("midrst_cnt", int'(a_cnt), 0);
        check("midrst_v1", int'(a_v1), 1);
        a_rst = 1'b0;
        c = cyc;
        s = c + 1;
        push_frame(1'b0, s, 1, 0, 5);
        wait_cyc(s + 3);
        a_run = 1'b0;
        wait_cyc(s + 16);
        check("restart_halted", int'(a_halted), 1);
        check("restart_cnt", int'(a_cnt), 1);
        wait_cyc(s + 20);
        check("restart_queue_empty", qa.size(), 0);

        // SUB_TICKS=3 spacing and 2-bit frame counter wrap over 5 frames
        b_rst = 1'b0;
        b_run = 1'b1;
        c = cyc;
        s = c + 1;
        for (int k = 0; k < 5; k++) begin
            push_frame(1'b1, s + 48 * k, 3, k % 4, 5);
        end
        wait_cyc(s + 48 * 4 + 20);
        b_run = 1'b0;
        wait_cyc(s + 239);
        check("b_still_running", int'(b_halted), 0);
        wait_cyc(s + 240);
        check("b_halted", int'(b_halted), 1);
        check("b_cnt_wrapped", int'(b_cnt), 1);
        wait_cyc(s + 250);
        check("b_v4_low_clks", b_v4_low, 20);
        check("b_v1_low_clks", b_v1_low, 15);
        check("b_queue_empty", qb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
